// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle sequencer and the fetch/register-file/ALU datapath.
//   master : the controller (consumes hold/instruction, drives stage, decode and counters)
//   slave  : the datapath side (drives hold/instruction, consumes everything else)
// Signals:
//   hold          freeze request (single-step/debug)
//   instruction   fetched instruction word, valid from the edge leaving IF
//   state         current stage (IF=0, ID=1, EX=2, WB=3, HALT=7)
//   alu_op        00 none, 01 add, 10 sub
//   alu_src_imm   ALU operand B is sign-extended imm
//   rs/rt/wr_addr register-file addresses
//   imm           latched instr[15:0]
//   rf_we         register-file write enable
//   illegal       latched instruction is unsupported
//   halted        sequencer has stopped
//   *_count       issued / retired / illegal instruction counters
interface multicycle_controller_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 hold;
  logic [31:0]          instruction;
  logic [2:0]           state;
  logic [1:0]           alu_op;
  logic                 alu_src_imm;
  logic [4:0]           rs_addr;
  logic [4:0]           rt_addr;
  logic [4:0]           wr_addr;
  logic [15:0]          imm;
  logic                 rf_we;
  logic                 illegal;
  logic                 halted;
  logic [CNT_WIDTH-1:0] issued_count;
  logic [CNT_WIDTH-1:0] retired_count;
  logic [CNT_WIDTH-1:0] illegal_count;

  modport master (
    input  hold, instruction,
    output state, alu_op, alu_src_imm, rs_addr, rt_addr, wr_addr, imm,
           rf_we, illegal, halted, issued_count, retired_count, illegal_count
  );

  modport slave (
    output hold, instruction,
    input  state, alu_op, alu_src_imm, rs_addr, rt_addr, wr_addr, imm,
           rf_we, illegal, halted, issued_count, retired_count, illegal_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main sequencer for the multi-cycle MIPS-subset core (addiu / addu / subu).
// Steps IF -> ID -> EX -> WB, decodes the instruction latched in ID into register-file and ALU
// controls, counts issued / retired / illegal instructions and halts once NUM_INSTR
// instructions have been issued and completed.
// Ports:
//   clk    system clock, all state on posedge
//   reset  asynchronous active-high reset
//   bus    controller side of the control bus (see multicycle_controller_if)
module multicycle_controller #(
  parameter int unsigned NUM_INSTR = 7,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StWb   = 3'd3,
    StHalt = 3'd7
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  state_e               state_q;
  logic [1:0]           alu_op_q;
  logic                 alu_src_imm_q;
  logic [4:0]           rs_addr_q;
  logic [4:0]           rt_addr_q;
  logic [4:0]           wr_addr_q;
  logic [15:0]          imm_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] issued_count_q;
  logic [CNT_WIDTH-1:0] retired_count_q;
  logic [CNT_WIDTH-1:0] illegal_count_q;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       dec_legal;
  logic [1:0] dec_alu_op;
  logic       dec_src_imm;
  logic [4:0] dec_wr_addr;
  logic       last_issued;

  // Shift amount is not part of the supported decode.
  logic unused_shamt;
  assign unused_shamt = ^bus.instruction[10:6];

  assign opcode = bus.instruction[31:26];
  assign funct  = bus.instruction[5:0];

  always_comb begin
    dec_legal   = 1'b0;
    dec_alu_op  = 2'b00;
    dec_src_imm = 1'b0;
    dec_wr_addr = 5'd0;
    if (opcode == OpAddiu) begin
      dec_legal   = 1'b1;
      dec_alu_op  = 2'b01;
      dec_src_imm = 1'b1;
      dec_wr_addr = bus.instruction[20:16];
    end else if (opcode == OpRType && funct == FnAddu) begin
      dec_legal   = 1'b1;
      dec_alu_op  = 2'b01;
      dec_wr_addr = bus.instruction[15:11];
    end else if (opcode == OpRType && funct == FnSubu) begin
      dec_legal   = 1'b1;
      dec_alu_op  = 2'b10;
      dec_wr_addr = bus.instruction[15:11];
    end
  end

  // The issue counter already includes the instruction leaving ID/WB, so equality means the
  // program is exhausted.
  assign last_issued = (issued_count_q == CNT_WIDTH'(NUM_INSTR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIf;
      alu_op_q        <= 2'b00;
      alu_src_imm_q   <= 1'b0;
      rs_addr_q       <= 5'd0;
      rt_addr_q       <= 5'd0;
      wr_addr_q       <= 5'd0;
      imm_q           <= 16'd0;
      illegal_q       <= 1'b0;
      issued_count_q  <= '0;
      retired_count_q <= '0;
      illegal_count_q <= '0;
    end else if (!bus.hold) begin
      case (state_q)
        StIf: begin
          state_q        <= StId;
          issued_count_q <= issued_count_q + 1'b1;
        end
        StId: begin
          alu_op_q      <= dec_alu_op;
          alu_src_imm_q <= dec_src_imm;
          rs_addr_q     <= bus.instruction[25:21];
          rt_addr_q     <= bus.instruction[20:16];
          wr_addr_q     <= dec_wr_addr;
          imm_q         <= bus.instruction[15:0];
          illegal_q     <= !dec_legal;
          if (dec_legal) begin
            state_q <= StEx;
          end else begin
            illegal_count_q <= illegal_count_q + 1'b1;
            state_q         <= last_issued ? StHalt : StIf;
          end
        end
        StEx: begin
          state_q <= StWb;
        end
        StWb: begin
          retired_count_q <= retired_count_q + 1'b1;
          state_q         <= last_issued ? StHalt : StIf;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIf;
        end
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.alu_src_imm   = alu_src_imm_q;
  assign bus.rs_addr       = rs_addr_q;
  assign bus.rt_addr       = rt_addr_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.imm           = imm_q;
  assign bus.illegal       = illegal_q;
  assign bus.halted        = (state_q == StHalt);
  assign bus.issued_count  = issued_count_q;
  assign bus.retired_count = retired_count_q;
  assign bus.illegal_count = illegal_count_q;
  // Hold suppresses the write so a frozen WB commits exactly once, when hold drops.
  assign bus.rf_we         = (state_q == StWb) && !bus.hold && !illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. The reference model describes the run as a
// timeline: each instruction occupies 4 (legal) or 2 (illegal) active cycles, and every output
// is derived from the number of non-held cycles elapsed since reset release.
module tb_multicycle_controller;
  localparam int N  = 7;
  localparam int CW = 8;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset1 = 1'b1;

  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_WIDTH(CW)) bus ();
  multicycle_controller_if #(.CNT_WIDTH(CW)) bus1 ();

  multicycle_controller #(.NUM_INSTR(N), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  multicycle_controller #(.NUM_INSTR(1), .CNT_WIDTH(CW)) dut1 (
    .clk  (clk),
    .reset(reset1),
    .bus  (bus1)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [N];
  int          st   [N];
  int          ln   [N];
  int          total;
  int          t;
  int          wq[$];
  int          aq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0d time=%0t)", name, act, exp, t, $time);
    end
  endtask

  function automatic int opc(input logic [31:0] w);
    return int'(w >> 26);
  endfunction

  function automatic int fnc(input logic [31:0] w);
    return int'(w & 32'h3f);
  endfunction

  function automatic bit legal(input logic [31:0] w);
    return (opc(w) == 9) || (opc(w) == 0 && (fnc(w) == 33 || fnc(w) == 35));
  endfunction

  function automatic void build();
    total = 0;
    for (int i = 0; i < N; i++) begin
      ln[i] = legal(prog[i]) ? 4 : 2;
      st[i] = total;
      total += ln[i];
    end
  endfunction

  // Stage and instruction index at elapsed active time t (7 / -1 once halted).
  function automatic int phase_at();
    for (int i = 0; i < N; i++) if (t >= st[i] && t < st[i] + ln[i]) return t - st[i];
    return 7;
  endfunction

  function automatic int k_at();
    for (int i = 0; i < N; i++) if (t >= st[i] && t < st[i] + ln[i]) return i;
    return -1;
  endfunction

  task automatic cmp(input bit h);
    int iss, ret, ill, lk, ph, e_op;
    logic [31:0] w;
    iss = 0; ret = 0; ill = 0; lk = -1;
    for (int i = 0; i < N; i++) begin
      if (st[i] < t) iss++;
      if (legal(prog[i]) && st[i] + 4 <= t) ret++;
      if (!legal(prog[i]) && st[i] + 2 <= t) ill++;
      if (st[i] + 2 <= t) lk = i;
    end
    ph = phase_at();
    check("state", int'(bus.state), ph);
    check("halted", int'(bus.halted), int'(ph == 7));
    check("issued", int'(bus.issued_count), iss % 256);
    check("retired", int'(bus.retired_count), ret % 256);
    check("illegal_cnt", int'(bus.illegal_count), ill % 256);
    check("rf_we", int'(bus.rf_we), int'(ph == 3 && !h));
    if (lk < 0) begin
      check("illegal_rst", int'(bus.illegal), 0);
      check("alu_op_rst", int'(bus.alu_op), 0);
      check("rs_rst", int'(bus.rs_addr), 0);
      check("imm_rst", int'(bus.imm), 0);
    end else begin
      w = prog[lk];
      e_op = !legal(w) ? 0 : (opc(w) == 0 && fnc(w) == 35) ? 2 : 1;
      check("illegal", int'(bus.illegal), int'(!legal(w)));
      check("alu_op", int'(bus.alu_op), e_op);
      check("rs_addr", int'(bus.rs_addr), int'((w >> 21) & 31));
      check("rt_addr", int'(bus.rt_addr), int'((w >> 16) & 31));
      check("imm", int'(bus.imm), int'(w & 32'hffff));
      if (legal(w)) begin
        check("alu_src_imm", int'(bus.alu_src_imm), int'(opc(w) == 9));
        check("wr_addr", int'(bus.wr_addr), opc(w) == 9 ? int'((w >> 16) & 31)
                                                        : int'((w >> 11) & 31));
      end
    end
  endtask

  // mode 0: no hold, 1: 5-cycle hold entering WB of instr 0, 2: random hold,
  // 3: asynchronous reset in EX of instr 3, then rerun.
  task automatic run(input int mode, output int cycles, output int pulses);
    int  ph, k, post, hold_left;
    bit  h, reached, fired, done_hold;
    post = 0; reached = 0; fired = 0; done_hold = 0; hold_left = 0;
    cycles = 0; pulses = 0;
    wq.delete(); aq.delete();
    t = 0;
    reset = 1'b1;
    bus.hold = 1'b1;
    bus.instruction = $urandom();
    repeat (2) @(negedge clk);
    #1 cmp(1'b1);
    bus.hold = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int it = 0; it < 400 && post < 20; it++) begin
      @(negedge clk);
      ph = phase_at();
      k  = k_at();
      h  = 1'b0;
      if (mode == 1) begin
        if (ph == 3 && k == 0 && !done_hold) begin
          hold_left = 5;
          done_hold = 1'b1;
        end
        if (hold_left > 0) begin
          h = 1'b1;
          hold_left--;
        end
      end else if (mode == 2) begin
        h = ($urandom_range(0, 3) == 0);
      end
      bus.hold = h;
      bus.instruction = (ph == 1) ? prog[k] : $urandom();
      #1 cmp(h);
      if (bus.rf_we) begin
        pulses++;
        wq.push_back(int'(bus.wr_addr));
        aq.push_back(int'(bus.alu_op));
      end
      if (mode == 3 && !fired && ph == 2 && k == 3) begin
        fired = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("async_state", int'(bus.state), 0);
        check("async_issued", int'(bus.issued_count), 0);
        check("async_retired", int'(bus.retired_count), 0);
        check("async_illegal", int'(bus.illegal_count), 0);
        check("async_rf_we", int'(bus.rf_we), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        t = 0; pulses = 0; cycles = 0;
        wq.delete(); aq.delete();
        continue;
      end
      if (t >= total) begin
        reached = 1'b1;
        post++;
      end
      @(posedge clk);
      if (t < total) begin
        cycles++;
        if (!h) t++;
      end
    end
    check("halt_reached", int'(reached), 1);
    if (mode == 3) check("reset_fired", int'(fired), 1);
  endtask

  task automatic gen_random();
    logic [4:0] a, b, c, s;
    for (int i = 0; i < N; i++) begin
      a = 5'($urandom()); b = 5'($urandom()); c = 5'($urandom()); s = 5'($urandom());
      case ($urandom_range(0, 4))
        0:       prog[i] = {6'b001001, a, b, 16'($urandom())};
        1:       prog[i] = {6'b000000, a, b, c, s, 6'b100001};
        2:       prog[i] = {6'b000000, a, b, c, s, 6'b100011};
        3:       prog[i] = 32'hFFFF_FFFF;
        default: prog[i] = $urandom();
      endcase
    end
  endtask

  initial begin
    int c, p;
    int ew [7];
    int ea [7];
    ew = '{1, 2, 3, 4, 5, 6, 5};
    ea = '{1, 1, 1, 1, 1, 1, 2};
    t = 0;
    prog = '{32'h2401_002D, 32'h2402_FFEC, 32'h2403_FFC4, 32'h2404_001E,
             32'h0022_2821, 32'h0064_3021, 32'h00A6_2823};
    build();
    bus.hold = 1'b0;
    bus.instruction = '0;

    // Single-instruction build.
    bus1.hold = 1'b0;
    bus1.instruction = 32'h2401_002D;
    @(negedge clk);
    #1 check("n1_reset_state", int'(bus1.state), 0);
    @(posedge clk);
    #1 reset1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("n1_wb_state", int'(bus1.state), 3);
    check("n1_rf_we", int'(bus1.rf_we), 1);
    @(posedge clk);
    @(negedge clk);
    check("n1_halt_state", int'(bus1.state), 7);
    check("n1_retired", int'(bus1.retired_count), 1);
    check("n1_issued", int'(bus1.issued_count), 1);

    // Standard program, no hold.
    run(0, c, p);
    check("std_cycles", c, 28);
    check("std_pulses", p, 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("std_wr%0d", i), (i < wq.size()) ? wq[i] : -1, ew[i]);
      check($sformatf("std_op%0d", i), (i < aq.size()) ? aq[i] : -1, ea[i]);
    end
    check("std_retired", int'(bus.retired_count), 7);
    check("std_issued", int'(bus.issued_count), 7);
    check("std_halted", int'(bus.halted), 1);

    // Hold in WB of instruction 0.
    run(1, c, p);
    check("hold_cycles", c, 33);
    check("hold_pulses", p, 7);

    // Asynchronous reset mid-EX, then a full rerun.
    run(3, c, p);
    check("rst_cycles", c, 28);
    check("rst_pulses", p, 7);
    check("rst_retired", int'(bus.retired_count), 7);

    // Mixed legal / illegal program.
    prog = '{32'h2401_002D, 32'hFFFF_FFFF, 32'h0022_2821, 32'h0000_0000,
             32'h00A6_2823, 32'hFFFF_FFFF, 32'h2404_001E};
    build();
    run(0, c, p);
    check("mix_cycles", c, 22);
    check("mix_pulses", p, 4);
    check("mix_illegal_cnt", int'(bus.illegal_count), 3);
    check("mix_retired", int'(bus.retired_count), 4);
    run(2, c, p);
    check("mix_rand_pulses", p, 4);

    // Random programs under random hold.
    for (int r = 0; r < 4; r++) begin
      gen_random();
      build();
      run(2, c, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main sequencer for the multi-cycle MIPS-subset core.
- Generates the 3-bit `state` consumed by the fetch stage and every later stage. Decodes the fetched instruction into control signals for register file and ALU. Counts issued and retired instructions.
- Halts after a fixed program length.
- Sits between fetch (which advances PC/instruction on posedge clk when state==STATE_IF) and the register-file/ALU datapath.

Parameters:
- NUM_INSTR, 7, number of instructions in instruction memory; controller halts after issuing this many.
- CNT_WIDTH, 8, width of issued/retired/illegal counters.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- hold  input  1  freeze request (single-step/debug); state and counters do not advance while 1.
- instruction  input  32  instruction word from fetch, valid from the posedge that leaves STATE_IF.
- state  output  3  current stage: STATE_IF=0, STATE_ID=1, STATE_EX=2, STATE_WB=3, STATE_HALT=7.
- alu_op  output  2  00 none, 01 add, 10 sub; registered in ID.
- alu_src_imm  output  1  1 = ALU operand B is sign-extended imm[15:0].
- rs_addr  output  5  source register 1 (instr[25:21]).
- rt_addr  output  5  source register 2 (instr[20:16]).
- wr_addr  output  5  destination: rt for addiu, rd (instr[15:11]) for addu/subu.
- imm  output  16  instr[15:0] latched.
- rf_we  output  1  register-file write enable.
- illegal  output  1  latched instruction in ID/EX/WB is unsupported.
- halted  output  1  state==STATE_HALT.
- issued_count  output  CNT_WIDTH  instructions fetched.
- retired_count  output  CNT_WIDTH  instructions completing WB.
- illegal_count  output  CNT_WIDTH  instructions dropped as illegal.

Behaviour:
- Reset (async, any time, including mid-instruction):
  - state=STATE_IF.
  - All decode registers and counters 0; rf_we=0, halted=0.
  - Fetch PC is not reset by this block; reset is applied at time 0 or together with fetch re-initialisation.
- Transitions, evaluated on posedge clk only when hold=0:
  - IF -> ID: issued_count+1.
  - ID -> EX for a legal instruction; ID -> IF for an illegal one (illegal_count+1).
  - EX -> WB.
  - WB -> IF: retired_count+1.
  - From WB, or from ID on an illegal instruction: if issued_count==NUM_INSTR, go to HALT instead of IF.
  - HALT is absorbing until reset; hold is ignored in HALT.
- Decode is latched at the posedge where state==STATE_ID, from `instruction` presented during ID:
  - opcode 001001 -> addiu: alu_op=01, alu_src_imm=1, wr_addr=rt.
  - opcode 000000, funct 100001 -> addu: alu_op=01, alu_src_imm=0, wr_addr=rd.
  - opcode 000000, funct 100011 -> subu: alu_op=10, alu_src_imm=0, wr_addr=rd.
  - Anything else: illegal=1, alu_op=00, rf_we never asserted.
- Decode outputs hold their values through EX and WB and until the next ID latch.
- rf_we = (state==STATE_WB) && !hold && !illegal. It is combinational from registered signals and is a one-cycle pulse per retired instruction.
- Latency:
  - Legal instruction: 4 cycles IF->IF.
  - Illegal instruction: 2 cycles.
  - Full legal program: 4*NUM_INSTR cycles from reset release to HALT.
- hold=1: state, counters and decode registers are frozen; rf_we is forced 0. Asserting hold in WB delays the write until the first cycle with hold=0.
- Counters wrap modulo 2^CNT_WIDTH; no saturation.
- reset and hold both asserted: reset wins.

Test Plan:
- Standard 7-instruction program (addiu $1/$2/$3/$4 with 45/-20/-60/30, addu $5, addu $6, subu $5), no hold:
  - HALT reached exactly 28 cycles after reset release.
  - rf_we pulses exactly 7 times, with wr_addr sequence 1,2,3,4,5,6,5.
  - alu_op sequence 01,01,01,01,01,01,10.
  - retired_count=7, issued_count=7, halted=1.
- Instruction word 0xFFFFFFFF at ID:
  - illegal=1, next state IF after 2 cycles.
  - illegal_count+1; no rf_we pulse; retired_count unchanged.
- hold=1 for 5 cycles entering WB of instruction 0:
  - state stays 3, rf_we=0 throughout hold.
  - Single rf_we pulse on the cycle hold drops; total run 33 cycles.
- reset pulsed asynchronously (mid-cycle) while in EX of instruction 3:
  - state=0, all counters 0, rf_we=0 immediately without waiting for a clock edge.
- Once halted:
  - Toggling hold and presenting new instructions keeps state=7 and counters constant for 20 cycles.
  - Reset returns state to 0.
- NUM_INSTR=1 override: HALT after 4 cycles, retired_count=1.
